// File: rtl/bus_dstb.sv
// bus_dstb: routes one upstream request to the lowest-index target whose masked base matches the address,
// with a decode-miss error response and an optional per-request timeout.
// Define BUS_DSTB_SKIP_EN to add bus_dstb_skip_o, which flags accesses to targets selected by SKIP_MASK.
module bus_dstb #(
    parameter int                  N_TGT     = 2,
    parameter logic [N_TGT*64-1:0] TGT_BASE  = {64'h0200_0000, 64'h0},
    parameter logic [N_TGT*64-1:0] TGT_MASK  = {64'hFFFF_FFFF_FFFF_0000, 64'h0},
    parameter int                  TIMEOUT   = 1024,
    parameter logic [N_TGT-1:0]    SKIP_MASK = 'b10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_dstb_valid_i,
    output logic                  bus_dstb_ready_o,
    output logic [63:0]           bus_dstb_data_read_o,
    input  logic [63:0]           bus_dstb_data_write_i,
    input  logic [63:0]           bus_dstb_addr_i,
    input  logic [1:0]            bus_dstb_size_i,
    input  logic                  bus_dstb_req_i,
    output logic [1:0]            bus_dstb_resp_o,
`ifdef BUS_DSTB_SKIP_EN
    output logic                  bus_dstb_skip_o,
`endif
    output logic [N_TGT-1:0]      bus_dstb_tgt_valid_o,
    input  logic [N_TGT-1:0]      bus_dstb_tgt_ready_i,
    input  logic [N_TGT*64-1:0]   bus_dstb_tgt_data_read_i,
    input  logic [N_TGT*2-1:0]    bus_dstb_tgt_resp_i,
    output logic [63:0]           bus_dstb_tgt_data_write_o,
    output logic [63:0]           bus_dstb_tgt_addr_o,
    output logic [1:0]            bus_dstb_tgt_size_o,
    output logic                  bus_dstb_tgt_req_o
);
    localparam int IW = $clog2(N_TGT);
    typedef enum logic [1:0] {IDLE, FWD, RESP, ERR} state_t;
    state_t           r_state;
    logic [IW-1:0]    r_idx, w_idx;
    logic             w_hit, w_fwd, w_tgt_rdy, w_tmo;
    logic [63:0]      r_addr, r_wdata, r_rdata, r_dout;
    logic [1:0]       r_size, r_rresp, r_resp;
    logic             r_req, r_ready;
    logic [31:0]      r_cnt;
    logic [N_TGT-1:0] r_tgt_valid;
`ifdef BUS_DSTB_SKIP_EN
    logic             r_skip;
    assign bus_dstb_skip_o = r_skip;
`endif
    assign w_fwd     = (r_state == FWD);
    assign w_tgt_rdy = bus_dstb_tgt_ready_i[r_idx];
    assign w_tmo     = (TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1));
    assign bus_dstb_ready_o          = r_ready;
    assign bus_dstb_data_read_o      = r_dout;
    assign bus_dstb_resp_o           = r_resp;
    assign bus_dstb_tgt_valid_o      = r_tgt_valid;
    assign bus_dstb_tgt_addr_o       = w_fwd ? r_addr  : '0;
    assign bus_dstb_tgt_data_write_o = w_fwd ? r_wdata : '0;
    assign bus_dstb_tgt_size_o       = w_fwd ? r_size  : '0;
    assign bus_dstb_tgt_req_o        = w_fwd ? r_req   : 1'b0;
    // address decode: scan from the top so the lowest matching index is the one left standing
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if ((bus_dstb_addr_i & TGT_MASK[64*i +: 64]) == TGT_BASE[64*i +: 64]) begin
                w_hit = 1'b1;
                w_idx = IW'(i);
            end
        end
    end
    // request FSM: accept and latch, forward to one target, then emit a one-cycle completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_req       <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= '0;
            r_cnt       <= '0;
            r_tgt_valid <= '0;
            r_ready     <= 1'b0;
            r_dout      <= '0;
            r_resp      <= '0;
`ifdef BUS_DSTB_SKIP_EN
            r_skip      <= 1'b0;
`endif
        end else begin
            r_ready <= 1'b0;
            r_dout  <= '0;
            r_resp  <= '0;
            case (r_state)
                IDLE: begin
                    if (bus_dstb_valid_i && w_hit) begin
                        r_idx       <= w_idx;
                        r_addr      <= bus_dstb_addr_i;
                        r_wdata     <= bus_dstb_data_write_i;
                        r_size      <= bus_dstb_size_i;
                        r_req       <= bus_dstb_req_i;
                        r_cnt       <= '0;
                        r_tgt_valid <= {{(N_TGT-1){1'b0}}, 1'b1} << w_idx;
`ifdef BUS_DSTB_SKIP_EN
                        r_skip      <= SKIP_MASK[w_idx];
`endif
                        r_state     <= FWD;
                    end else if (bus_dstb_valid_i) begin
                        r_state <= ERR;
                    end
                end
                FWD: begin
                    if (w_tgt_rdy) begin
                        r_rdata     <= bus_dstb_tgt_data_read_i[64*int'(r_idx) +: 64];
                        r_rresp     <= bus_dstb_tgt_resp_i[2*int'(r_idx) +: 2];
                        r_tgt_valid <= '0;
                        r_state     <= RESP;
                    end else if (w_tmo) begin
                        r_rdata     <= '0;
                        r_rresp     <= 2'b10;
                        r_tgt_valid <= '0;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                RESP: begin
                    r_ready <= 1'b1;
                    r_dout  <= r_rdata;
                    r_resp  <= r_rresp;
`ifdef BUS_DSTB_SKIP_EN
                    r_skip  <= 1'b0;
`endif
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_resp  <= 2'b11;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
